// File: rtl/pio_arbiter.sv
// -----------------------------------------------------------------------------
// pio_arbiter
//
// Shares the single parallel-port (PIO) access path between the I-RAM page-in
// engine and the CPU data port. A page-in issues one command word on the
// instruction command-write channel, then reads a whole page word by word on
// the instruction burst-read channel and writes each word into I-RAM. CPU data
// accesses are forwarded to the PIO data channel. This block owns every PIO
// enable, and at most one of them is high in any cycle.
//
// Ports:
//   Clk, Reset               clock, asynchronous active-high reset
//   iMissReq, iMissPage      page-miss request (level) and missing page number
//   oMissDone                one-cycle pulse when the whole page is in I-RAM
//   oIRamWe/Addr/Data        I-RAM write port
//   iDReq, iDWe, iDAddr,
//   iDData                   CPU data-port request (level) and its operands
//   oDAck, oDData            one-cycle completion pulse, held read data
//   oPAddr, oPData           PIO port address and write data
//   oPREnb, oPWEnb           PIO data read / write enables
//   oPREnbI, oPWEnbI         PIO instruction burst-read / command-write enables
//   iPAck, iPAckI, iPData    PIO data / instruction acks and read data
// All outputs are registered.
// -----------------------------------------------------------------------------
module pio_arbiter #(
    parameter int         DATA_W       = 16,
    parameter int         OFS_W        = 6,
    parameter int         IRAM_AW      = 10,
    parameter int         PAGE_W       = 8,
    parameter logic [6:0] PORT_PAGE_IN = 7'h40
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               iMissReq,
    input  logic [PAGE_W-1:0]  iMissPage,
    output logic               oMissDone,
    output logic               oIRamWe,
    output logic [IRAM_AW-1:0] oIRamAddr,
    output logic [DATA_W-1:0]  oIRamData,
    input  logic               iDReq,
    input  logic               iDWe,
    input  logic [6:0]         iDAddr,
    input  logic [DATA_W-1:0]  iDData,
    output logic               oDAck,
    output logic [DATA_W-1:0]  oDData,
    output logic [6:0]         oPAddr,
    output logic [DATA_W-1:0]  oPData,
    output logic               oPREnb,
    output logic               oPWEnb,
    output logic               oPREnbI,
    output logic               oPWEnbI,
    input  logic               iPAck,
    input  logic               iPAckI,
    input  logic [DATA_W-1:0]  iPData
);

    localparam int SLOT_W = IRAM_AW - OFS_W;
    localparam logic [OFS_W-1:0] LAST_OFS = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DACC,
        S_PCMD,
        S_PREAD,
        S_PDONE
    } state_t;

    state_t              state, state_next;
    logic [SLOT_W-1:0]   page_slot, page_slot_next;
    logic [OFS_W-1:0]    counter, counter_next;
    logic                last_was_page, last_was_page_next;

    logic [6:0]          p_addr_next;
    logic [DATA_W-1:0]   p_data_next;
    logic                p_renb_next, p_wenb_next, p_renb_i_next, p_wenb_i_next;
    logic                d_ack_next;
    logic [DATA_W-1:0]   d_data_next;
    logic                miss_done_next;
    logic                iram_we_next;
    logic [IRAM_AW-1:0]  iram_addr_next;
    logic [DATA_W-1:0]   iram_data_next;

    // A requester keeps its level high during the cycle its completion pulse
    // is visible, so that request is not re-arbitrated in that cycle. The
    // other requester may still be granted straight away.
    logic page_req_live, data_req_live;
    assign page_req_live = iMissReq && !oMissDone;
    assign data_req_live = iDReq && !oDAck;

    // Next-state and next-output logic. Enables and address/data hold their
    // value by default; pulses (oDAck, oMissDone, oIRamWe) default low.
    always_comb begin
        state_next         = state;
        page_slot_next     = page_slot;
        counter_next       = counter;
        last_was_page_next = last_was_page;
        p_addr_next        = oPAddr;
        p_data_next        = oPData;
        p_renb_next        = oPREnb;
        p_wenb_next        = oPWEnb;
        p_renb_i_next      = oPREnbI;
        p_wenb_i_next      = oPWEnbI;
        d_ack_next         = 1'b0;
        d_data_next        = oDData;
        miss_done_next     = 1'b0;
        iram_we_next       = 1'b0;
        iram_addr_next     = oIRamAddr;
        iram_data_next     = oIRamData;

        case (state)
            S_IDLE: begin
                // Page wins a tie unless the previous grant was a page load.
                if (page_req_live && (!data_req_live || !last_was_page)) begin
                    page_slot_next = iMissPage[SLOT_W-1:0];
                    p_addr_next    = PORT_PAGE_IN;
                    p_data_next    = DATA_W'(iMissPage);
                    p_wenb_i_next  = 1'b1;
                    state_next     = S_PCMD;
                end else if (data_req_live) begin
                    p_addr_next        = iDAddr;
                    p_data_next        = iDData;
                    p_wenb_next        = iDWe;
                    p_renb_next        = !iDWe;
                    last_was_page_next = 1'b0;
                    state_next         = S_DACC;
                end
            end

            S_DACC: begin
                if (iPAck) begin
                    p_wenb_next = 1'b0;
                    p_renb_next = 1'b0;
                    d_ack_next  = 1'b1;
                    if (oPREnb) begin
                        d_data_next = iPData;
                    end
                    state_next = S_IDLE;
                end
            end

            S_PCMD: begin
                // The first word read is issued together with the command drop.
                if (iPAckI) begin
                    p_wenb_i_next = 1'b0;
                    p_renb_i_next = 1'b1;
                    counter_next  = '0;
                    state_next    = S_PREAD;
                end
            end

            S_PREAD: begin
                if (oPREnbI) begin
                    if (iPAckI) begin
                        p_renb_i_next  = 1'b0;
                        iram_we_next   = 1'b1;
                        iram_data_next = iPData;
                        iram_addr_next = {page_slot, counter};
                        counter_next   = counter + OFS_W'(1);
                        if (counter == LAST_OFS) begin
                            last_was_page_next = 1'b1;
                            state_next         = S_PDONE;
                        end
                    end
                end else begin
                    // One idle cycle between words, then the next read.
                    p_renb_i_next = 1'b1;
                end
            end

            S_PDONE: begin
                miss_done_next = 1'b1;
                state_next     = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset drops every enable immediately and
    // abandons any page load in progress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_IDLE;
            page_slot     <= '0;
            counter       <= '0;
            last_was_page <= 1'b0;
            oPAddr        <= '0;
            oPData        <= '0;
            oPREnb        <= 1'b0;
            oPWEnb        <= 1'b0;
            oPREnbI       <= 1'b0;
            oPWEnbI       <= 1'b0;
            oDAck         <= 1'b0;
            oDData        <= '0;
            oMissDone     <= 1'b0;
            oIRamWe       <= 1'b0;
            oIRamAddr     <= '0;
            oIRamData     <= '0;
        end else begin
            state         <= state_next;
            page_slot     <= page_slot_next;
            counter       <= counter_next;
            last_was_page <= last_was_page_next;
            oPAddr        <= p_addr_next;
            oPData        <= p_data_next;
            oPREnb        <= p_renb_next;
            oPWEnb        <= p_wenb_next;
            oPREnbI       <= p_renb_i_next;
            oPWEnbI       <= p_wenb_i_next;
            oDAck         <= d_ack_next;
            oDData        <= d_data_next;
            oMissDone     <= miss_done_next;
            oIRamWe       <= iram_we_next;
            oIRamAddr     <= iram_addr_next;
            oIRamData     <= iram_data_next;
        end
    end

endmodule

// File: tb/tb_pio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pio_arbiter
//
// Drives pio_arbiter with directed and randomized CPU data accesses and page
// loads. A behavioural PIO responder acknowledges enables after a programmable
// number of wait cycles; page-read words carry (word index ^ FFFF) ^ salt so
// the expected I-RAM contents follow directly from page number and index.
// -----------------------------------------------------------------------------
module tb_pio_arbiter;

    logic        Clk;
    logic        Reset;
    logic        iMissReq;
    logic [7:0]  iMissPage;
    logic        oMissDone;
    logic        oIRamWe;
    logic [9:0]  oIRamAddr;
    logic [15:0] oIRamData;
    logic        iDReq;
    logic        iDWe;
    logic [6:0]  iDAddr;
    logic [15:0] iDData;
    logic        oDAck;
    logic [15:0] oDData;
    logic [6:0]  oPAddr;
    logic [15:0] oPData;
    logic        oPREnb;
    logic        oPWEnb;
    logic        oPREnbI;
    logic        oPWEnbI;
    logic        iPAck  = 1'b0;
    logic        iPAckI = 1'b0;
    logic [15:0] iPData = 16'h0000;

    pio_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .iMissReq  (iMissReq),
        .iMissPage (iMissPage),
        .oMissDone (oMissDone),
        .oIRamWe   (oIRamWe),
        .oIRamAddr (oIRamAddr),
        .oIRamData (oIRamData),
        .iDReq     (iDReq),
        .iDWe      (iDWe),
        .iDAddr    (iDAddr),
        .iDData    (iDData),
        .oDAck     (oDAck),
        .oDData    (oDData),
        .oPAddr    (oPAddr),
        .oPData    (oPData),
        .oPREnb    (oPREnb),
        .oPWEnb    (oPWEnb),
        .oPREnbI   (oPREnbI),
        .oPWEnbI   (oPWEnbI),
        .iPAck     (iPAck),
        .iPAckI    (iPAckI),
        .iPData    (iPData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder controls.
    int          pio_wait   = 0;
    logic [15:0] rd_value   = 16'h0000;
    logic [15:0] salt       = 16'h0000;
    bit          spur_ack   = 1'b0;
    bit          spur_ack_i = 1'b0;
    int          wc         = 0;
    int          ridx       = 0;

    // Observations collected by the monitor.
    int          wenb_cyc, renb_cyc, cmd_cnt, dack_cnt, done_cnt;
    logic [6:0]  mon_paddr, cmd_addr;
    logic [15:0] mon_pdata, cmd_data;
    logic [9:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic        prev_wenbi = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural PIO: acks any enable after pio_wait cycles of it being high.
    always begin
        @(posedge Clk);
        #1;
        iPAck  = 1'b0;
        iPAckI = 1'b0;
        if (oPWEnb || oPREnb || oPWEnbI || oPREnbI) begin
            if (wc >= pio_wait) begin
                wc = 0;
                if (oPWEnb || oPREnb) begin
                    iPAck = 1'b1;
                    if (oPREnb) iPData = rd_value;
                end else if (oPWEnbI) begin
                    iPAckI = 1'b1;
                    ridx   = 0;
                end else begin
                    iPAckI = 1'b1;
                    iPData = 16'(ridx ^ 32'h0000_FFFF) ^ salt;
                    ridx++;
                end
            end else begin
                wc++;
            end
        end else begin
            wc = 0;
        end
        if (spur_ack) begin
            iPAck    = 1'b1;
            spur_ack = 1'b0;
        end
        if (spur_ack_i) begin
            iPAckI     = 1'b1;
            spur_ack_i = 1'b0;
        end
    end

    // Monitor: enable exclusivity every cycle plus event bookkeeping.
    always @(posedge Clk) begin
        #1;
        if (!Reset) begin
            checkOutput("enable_onehot", 32'($countones({oPREnb, oPWEnb, oPREnbI, oPWEnbI}) <= 1), 32'd1);
            if (oPWEnb) begin
                wenb_cyc++;
                mon_paddr = oPAddr;
                mon_pdata = oPData;
            end
            if (oPREnb) begin
                renb_cyc++;
                mon_paddr = oPAddr;
            end
            if (oPWEnbI && !prev_wenbi) begin
                cmd_cnt++;
                cmd_addr = oPAddr;
                cmd_data = oPData;
            end
            if (oDAck) dack_cnt++;
            if (oMissDone) done_cnt++;
            if (oIRamWe) begin
                wr_addr_q.push_back(oIRamAddr);
                wr_data_q.push_back(oIRamData);
            end
        end
        prev_wenbi = oPWEnbI;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_stats();
        wenb_cyc  = 0;
        renb_cyc  = 0;
        cmd_cnt   = 0;
        dack_cnt  = 0;
        done_cnt  = 0;
        mon_paddr = 'x;
        mon_pdata = 'x;
        cmd_addr  = 'x;
        cmd_data  = 'x;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [15:0] wdata);
        iDWe   = we;
        iDAddr = addr;
        iDData = wdata;
        iDReq  = 1'b1;
    endtask

    task automatic wait_for_ack(input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge Clk);
            cyc++;
            if (oDAck) got = 1'b1;
        end
    endtask

    task automatic wait_for_done(input int budget, output bit got);
        int cyc;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge Clk);
            cyc++;
            if (oMissDone) got = 1'b1;
        end
    endtask

    // One data access; latency counted from the request edge to oDAck.
    task automatic data_access(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                               input logic [15:0] rdata, input int waitc);
        bit got;
        int cyc;
        clear_stats();
        pio_wait = waitc;
        rd_value = rdata;
        applyStimulus(we, addr, wdata);
        wait_for_ack(40, got, cyc);
        iDReq = 1'b0;
        @(negedge Clk);
        checkOutput("dacc_ack_seen", 32'(got), 32'd1);
        checkOutput("dacc_latency", 32'(cyc), 32'(2 + waitc));
        checkOutput("dacc_ack_pulses", 32'(dack_cnt), 32'd1);
        checkOutput("dacc_paddr", 32'(mon_paddr), 32'(addr));
        if (we) begin
            checkOutput("dacc_wenb_cycles", 32'(wenb_cyc), 32'(waitc + 1));
            checkOutput("dacc_renb_cycles", 32'(renb_cyc), 32'd0);
            checkOutput("dacc_pdata", 32'(mon_pdata), 32'(wdata));
        end else begin
            checkOutput("dacc_renb_cycles", 32'(renb_cyc), 32'(waitc + 1));
            checkOutput("dacc_wenb_cycles", 32'(wenb_cyc), 32'd0);
            checkOutput("dacc_rdata", 32'(oDData), 32'(rdata));
        end
    endtask

    task automatic check_page_writes(input int base, input int page, input logic [15:0] s);
        for (int k = 0; k < 64; k++) begin
            if (base + k < wr_addr_q.size()) begin
                checkOutput("iram_addr", 32'(wr_addr_q[base + k]), 32'((page % 16) * 64 + k));
                checkOutput("iram_data", 32'(wr_data_q[base + k]), 32'(16'(k ^ 32'h0000_FFFF) ^ s));
            end
        end
    endtask

    // One complete page load; iMissPage is scrambled after the grant.
    task automatic page_in(input logic [7:0] page, input logic [15:0] s, input int waitc, input bit spur);
        bit got;
        int cyc;
        clear_stats();
        salt      = s;
        pio_wait  = waitc;
        iMissPage = page;
        iMissReq  = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        iMissPage = ~page;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 64 * (waitc + 2) + 40) begin
            @(negedge Clk);
            cyc++;
            if (spur && cyc == 10) spur_ack = 1'b1;
            if (oMissDone) got = 1'b1;
        end
        iMissReq = 1'b0;
        @(negedge Clk);
        checkOutput("page_done_seen", 32'(got), 32'd1);
        checkOutput("page_done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("page_cmd_count", 32'(cmd_cnt), 32'd1);
        checkOutput("page_cmd_addr", 32'(cmd_addr), 32'h40);
        checkOutput("page_cmd_data", 32'(cmd_data), 32'(page));
        checkOutput("page_no_dack", 32'(dack_cnt), 32'd0);
        checkOutput("page_word_count", 32'(wr_addr_q.size()), 32'd64);
        check_page_writes(0, int'(page), s);
    endtask

    initial begin
        bit          got;
        int          cyc;
        logic [7:0]  rpage;
        logic [15:0] rval;

        Reset     = 1'b1;
        iMissReq  = 1'b0;
        iMissPage = 8'h00;
        iDReq     = 1'b0;
        iDWe      = 1'b0;
        iDAddr    = 7'h00;
        iDData    = 16'h0000;
        clear_stats();
        repeat (3) @(negedge Clk);
        checkOutput("rst_enables", 32'({oPREnb, oPWEnb, oPREnbI, oPWEnbI}), 32'd0);
        checkOutput("rst_pulses", 32'({oMissDone, oDAck, oIRamWe}), 32'd0);
        checkOutput("rst_paddr", 32'(oPAddr), 32'd0);
        checkOutput("rst_pdata", 32'(oPData), 32'd0);
        checkOutput("rst_iram_addr", 32'(oIRamAddr), 32'd0);
        checkOutput("rst_iram_data", 32'(oIRamData), 32'd0);
        checkOutput("rst_ddata", 32'(oDData), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        $display("[TB] directed data write and read");
        data_access(1'b1, 7'h05, 16'hA5C3, 16'h0000, 2);
        data_access(1'b0, 7'h12, 16'h0000, 16'h1234, 0);
        data_access(1'b1, 7'h06, 16'h0F0F, 16'h0000, 1);
        checkOutput("ddata_held", 32'(oDData), 32'h1234);

        $display("[TB] spurious acks while idle");
        clear_stats();
        spur_ack   = 1'b1;
        spur_ack_i = 1'b1;
        repeat (4) @(negedge Clk);
        checkOutput("idle_spur_dack", 32'(dack_cnt), 32'd0);
        checkOutput("idle_spur_writes", 32'(wr_addr_q.size()), 32'd0);
        checkOutput("idle_spur_done", 32'(done_cnt), 32'd0);

        $display("[TB] page-in of page 0B with a spurious data ack");
        page_in(8'h0B, 16'h0000, 0, 1'b1);
        data_access(1'b0, 7'h20, 16'h0000, 16'hCAFE, 1);

        $display("[TB] contention between page-in and data read");
        clear_stats();
        salt      = 16'h0000;
        pio_wait  = 0;
        rd_value  = 16'hBEEF;
        iMissPage = 8'h21;
        iMissReq  = 1'b1;
        applyStimulus(1'b0, 7'h33, 16'h0000);
        wait_for_done(200, got);
        checkOutput("contend_page_first", 32'(got), 32'd1);
        checkOutput("contend_no_dack_yet", 32'(dack_cnt), 32'd0);
        iMissPage = 8'h22;
        wait_for_ack(10, got, cyc);
        iDReq = 1'b0;
        checkOutput("contend_data_next", 32'(got), 32'd1);
        checkOutput("contend_data_latency", 32'(cyc), 32'd2);
        checkOutput("contend_cmds_before_data", 32'(cmd_cnt), 32'd1);
        checkOutput("contend_rdata", 32'(oDData), 32'hBEEF);
        wait_for_done(200, got);
        iMissReq = 1'b0;
        @(negedge Clk);
        checkOutput("contend_second_page", 32'(got), 32'd1);
        checkOutput("contend_cmds_total", 32'(cmd_cnt), 32'd2);
        checkOutput("contend_words_total", 32'(wr_addr_q.size()), 32'd128);
        check_page_writes(0, 'h21, 16'h0000);
        check_page_writes(64, 'h22, 16'h0000);

        $display("[TB] reset in the middle of a page load");
        clear_stats();
        salt      = 16'h0000;
        pio_wait  = 0;
        iMissPage = 8'h37;
        iMissReq  = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            if (wr_addr_q.size() >= 11) got = 1'b1;
        end
        checkOutput("midreset_reached_word10", 32'(got), 32'd1);
        checkOutput("midreset_words_before", 32'(wr_addr_q.size()), 32'd11);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("midreset_enables_drop", 32'({oPREnb, oPWEnb, oPREnbI, oPWEnbI}), 32'd0);
        iMissReq = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checkOutput("midreset_no_done", 32'(done_cnt), 32'd0);
        page_in(8'h37, 16'h5A5A, 1, 1'b0);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 12; i++) begin
            rval = 16'($urandom);
            case ($urandom_range(0, 2))
                0: data_access(1'b1, 7'($urandom), rval, 16'h0000, int'($urandom_range(0, 3)));
                1: data_access(1'b0, 7'($urandom), 16'h0000, rval, int'($urandom_range(0, 3)));
                default: begin
                    rpage = 8'($urandom);
                    page_in(rpage, rval, int'($urandom_range(0, 2)), 1'b0);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
